// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared SAP opcodes, T-state indices and control-word layout
package sap_pkg;

  // Opcodes are held at the widest legal OPW (8); narrower IR fields are zero-extended before compare.
  localparam int OPW_MAX = 8;

  typedef enum logic [OPW_MAX-1:0] {
    OP_LDA = 8'h00,
    OP_ADD = 8'h01,
    OP_SUB = 8'h02,
    OP_STA = 8'h04,
    OP_LDI = 8'h05,
    OP_JMP = 8'h06,
    OP_JC  = 8'h07,
    OP_JZ  = 8'h08,
    OP_OUT = 8'h0E,
    OP_HLT = 8'h0F
  } opcode_e;

  localparam int TW = 6;
  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;

  localparam int CW_PC_INC   = 0;
  localparam int CW_PC_OUT   = 1;
  localparam int CW_PC_LOAD  = 2;
  localparam int CW_MAR_LOAD = 3;
  localparam int CW_RAM_OUT  = 4;
  localparam int CW_RAM_IN   = 5;
  localparam int CW_IR_LOAD  = 6;
  localparam int CW_IR_OUT   = 7;
  localparam int CW_A_LOAD   = 8;
  localparam int CW_A_OUT    = 9;
  localparam int CW_B_LOAD   = 10;
  localparam int CW_ALU_SUB  = 11;
  localparam int CW_ALU_OUT  = 12;
  localparam int CW_OUT_LOAD = 13;
  localparam int CW_W        = 14;

  typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/sap_tstate_ring.sv
// rtl/sap_tstate_ring.sv - one-hot six-step T-state ring with hold and clear-to-T1
import sap_pkg::*;

module sap_tstate_ring (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_hold,
  input  logic          i_clr,
  output logic [TW-1:0] o_t_state
);

  logic [TW-1:0] r_ring;

  // Clear only takes effect on an advancing edge, so a stepped-off ring never skips.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ring <= TW'(1);
    end else if (i_en && !i_hold) begin
      if (i_clr) begin
        r_ring <= TW'(1);
      end else begin
        r_ring <= {r_ring[TW-2:0], r_ring[TW-1]};
      end
    end
  end

  assign o_t_state = r_ring;

endmodule

// File: rtl/sap_ctrl_seq.sv
// rtl/sap_ctrl_seq.sv - SAP controller-sequencer: T-state ring, sticky halt, control-word decode
import sap_pkg::*;

module sap_ctrl_seq #(
  parameter int OPW       = 4,
  parameter int EARLY_END = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           step_en,
  input  logic [OPW-1:0] opcode,
  input  logic           flag_c,
  input  logic           flag_z,
  output logic [TW-1:0]  t_state,
  output logic           pc_inc,
  output logic           pc_out,
  output logic           pc_load,
  output logic           mar_load,
  output logic           ram_out,
  output logic           ram_in,
  output logic           ir_load,
  output logic           ir_out,
  output logic           a_load,
  output logic           a_out,
  output logic           b_load,
  output logic           alu_sub,
  output logic           alu_out,
  output logic           out_load,
  output logic           halted
);

  logic [OPW_MAX-1:0] w_op;
  ctrl_word_t         w_cw;
  logic               w_last;
  logic               w_halt_set;
  logic               r_halted;

  assign w_op = OPW_MAX'(opcode);

  sap_tstate_ring u_ring (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (step_en),
    .i_hold    (r_halted),
    .i_clr     ((EARLY_END != 0) && w_last),
    .o_t_state (t_state)
  );

  // HLT's T4 is deliberately not a last step, so the ring lands on T5 as halt takes hold.
  assign w_halt_set = step_en && !r_halted && t_state[T4] && (w_op == OP_HLT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (w_halt_set) begin
      r_halted <= 1'b1;
    end
  end

  always_comb begin
    w_cw   = '0;
    w_last = 1'b0;
    if (!r_halted) begin
      if (t_state[T1]) begin
        w_cw[CW_PC_OUT]   = 1'b1;
        w_cw[CW_MAR_LOAD] = 1'b1;
      end
      if (t_state[T2]) begin
        w_cw[CW_PC_INC] = 1'b1;
      end
      if (t_state[T3]) begin
        w_cw[CW_RAM_OUT] = 1'b1;
        w_cw[CW_IR_LOAD] = 1'b1;
      end
      if (t_state[T4]) begin
        case (w_op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            w_cw[CW_IR_OUT]   = 1'b1;
            w_cw[CW_MAR_LOAD] = 1'b1;
          end
          OP_LDI: begin
            w_cw[CW_IR_OUT] = 1'b1;
            w_cw[CW_A_LOAD] = 1'b1;
            w_last          = 1'b1;
          end
          OP_JMP: begin
            w_cw[CW_IR_OUT]  = 1'b1;
            w_cw[CW_PC_LOAD] = 1'b1;
            w_last           = 1'b1;
          end
          OP_JC: begin
            w_cw[CW_IR_OUT]  = flag_c;
            w_cw[CW_PC_LOAD] = flag_c;
            w_last           = 1'b1;
          end
          OP_JZ: begin
            w_cw[CW_IR_OUT]  = flag_z;
            w_cw[CW_PC_LOAD] = flag_z;
            w_last           = 1'b1;
          end
          OP_OUT: begin
            w_cw[CW_A_OUT]    = 1'b1;
            w_cw[CW_OUT_LOAD] = 1'b1;
            w_last            = 1'b1;
          end
          OP_HLT: begin
          end
          default: begin
            w_last = 1'b1;
          end
        endcase
      end
      if (t_state[T5]) begin
        case (w_op)
          OP_LDA: begin
            w_cw[CW_RAM_OUT] = 1'b1;
            w_cw[CW_A_LOAD]  = 1'b1;
            w_last           = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_cw[CW_RAM_OUT] = 1'b1;
            w_cw[CW_B_LOAD]  = 1'b1;
            w_cw[CW_ALU_SUB] = (w_op == OP_SUB);
          end
          OP_STA: begin
            w_cw[CW_A_OUT]  = 1'b1;
            w_cw[CW_RAM_IN] = 1'b1;
            w_last          = 1'b1;
          end
          default: begin
          end
        endcase
      end
      if (t_state[T6]) begin
        if ((w_op == OP_ADD) || (w_op == OP_SUB)) begin
          w_cw[CW_ALU_OUT] = 1'b1;
          w_cw[CW_A_LOAD]  = 1'b1;
          w_cw[CW_ALU_SUB] = (w_op == OP_SUB);
          w_last           = 1'b1;
        end
      end
    end
  end

  assign pc_inc   = w_cw[CW_PC_INC];
  assign pc_out   = w_cw[CW_PC_OUT];
  assign pc_load  = w_cw[CW_PC_LOAD];
  assign mar_load = w_cw[CW_MAR_LOAD];
  assign ram_out  = w_cw[CW_RAM_OUT];
  assign ram_in   = w_cw[CW_RAM_IN];
  assign ir_load  = w_cw[CW_IR_LOAD];
  assign ir_out   = w_cw[CW_IR_OUT];
  assign a_load   = w_cw[CW_A_LOAD];
  assign a_out    = w_cw[CW_A_OUT];
  assign b_load   = w_cw[CW_B_LOAD];
  assign alu_sub  = w_cw[CW_ALU_SUB];
  assign alu_out  = w_cw[CW_ALU_OUT];
  assign out_load = w_cw[CW_OUT_LOAD];
  assign halted   = r_halted;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// tb/tb_sap_ctrl_seq.sv - scoreboard bench for sap_ctrl_seq, early-end and classic timing
module tb_sap_ctrl_seq;

  localparam logic [13:0] C_PC_INC   = 14'd1 << 13;
  localparam logic [13:0] C_PC_OUT   = 14'd1 << 12;
  localparam logic [13:0] C_PC_LOAD  = 14'd1 << 11;
  localparam logic [13:0] C_MAR      = 14'd1 << 10;
  localparam logic [13:0] C_RAM_OUT  = 14'd1 << 9;
  localparam logic [13:0] C_RAM_IN   = 14'd1 << 8;
  localparam logic [13:0] C_IR_LOAD  = 14'd1 << 7;
  localparam logic [13:0] C_IR_OUT   = 14'd1 << 6;
  localparam logic [13:0] C_A_LOAD   = 14'd1 << 5;
  localparam logic [13:0] C_A_OUT    = 14'd1 << 4;
  localparam logic [13:0] C_B_LOAD   = 14'd1 << 3;
  localparam logic [13:0] C_SUB      = 14'd1 << 2;
  localparam logic [13:0] C_ALU_OUT  = 14'd1 << 1;
  localparam logic [13:0] C_OUT_LOAD = 14'd1 << 0;
  localparam logic [13:0] C_NONE     = 14'd0;

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

  logic       clk = 1'b0;
  logic       rst;
  logic       step_en;
  logic [3:0] opcode;
  logic       flag_c;
  logic       flag_z;

  wire [5:0]  t1, t0;
  wire [13:0] cw1, cw0;
  wire        h1, h0;

  typedef struct {
    bit         sel;
    logic [5:0] t;
    logic [13:0] cw;
    logic       h;
    string      nm;
  } sb_t;

  sb_t q[$];
  sb_t e;
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  sap_ctrl_seq #(.OPW(4), .EARLY_END(1)) dut (
    .clk(clk), .rst(rst), .step_en(step_en), .opcode(opcode),
    .flag_c(flag_c), .flag_z(flag_z), .t_state(t1),
    .pc_inc(cw1[13]), .pc_out(cw1[12]), .pc_load(cw1[11]), .mar_load(cw1[10]),
    .ram_out(cw1[9]), .ram_in(cw1[8]), .ir_load(cw1[7]), .ir_out(cw1[6]),
    .a_load(cw1[5]), .a_out(cw1[4]), .b_load(cw1[3]), .alu_sub(cw1[2]),
    .alu_out(cw1[1]), .out_load(cw1[0]), .halted(h1)
  );

  sap_ctrl_seq #(.OPW(4), .EARLY_END(0)) dut_classic (
    .clk(clk), .rst(rst), .step_en(step_en), .opcode(opcode),
    .flag_c(flag_c), .flag_z(flag_z), .t_state(t0),
    .pc_inc(cw0[13]), .pc_out(cw0[12]), .pc_load(cw0[11]), .mar_load(cw0[10]),
    .ram_out(cw0[9]), .ram_in(cw0[8]), .ir_load(cw0[7]), .ir_out(cw0[6]),
    .a_load(cw0[5]), .a_out(cw0[4]), .b_load(cw0[3]), .alu_sub(cw0[2]),
    .alu_out(cw0[1]), .out_load(cw0[0]), .halted(h0)
  );

  function automatic int drivers(input logic [13:0] cw);
    return $countones({cw[12], cw[9], cw[6], cw[4], cw[1]});
  endfunction

  // Monitor: every cycle, bus-driver exclusivity on both instances plus one scoreboard pop.
  always @(negedge clk) begin
    n_checks = n_checks + 2;
    if (drivers(cw1) > 1) begin
      n_fail = n_fail + 1;
      $display("FAIL bus_excl_early: cw=%b has %0d drivers, required <=1", cw1, drivers(cw1));
    end
    if (drivers(cw0) > 1) begin
      n_fail = n_fail + 1;
      $display("FAIL bus_excl_classic: cw=%b has %0d drivers, required <=1", cw0, drivers(cw0));
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks = n_checks + 1;
      if (e.sel ? ({t1, cw1, h1} !== {e.t, e.cw, e.h}) : ({t0, cw0, h0} !== {e.t, e.cw, e.h})) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got t=%b cw=%b halted=%b, expected t=%b cw=%b halted=%b",
                 e.nm, e.sel ? t1 : t0, e.sel ? cw1 : cw0, e.sel ? h1 : h0, e.t, e.cw, e.h);
      end
    end
  end

  task automatic cyc(input bit sel, input logic [5:0] t, input logic [13:0] cw,
                     input logic h, input string nm);
    sb_t x;
    x.sel = sel; x.t = t; x.cw = cw; x.h = h; x.nm = nm;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input bit sel, input string nm);
    cyc(sel, S1, C_PC_OUT | C_MAR, 1'b0, {nm, "_t1"});
    cyc(sel, S2, C_PC_INC, 1'b0, {nm, "_t2"});
    cyc(sel, S3, C_RAM_OUT | C_IR_LOAD, 1'b0, {nm, "_t3"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; step_en = 1'b1; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, S1, C_PC_OUT | C_MAR, 1'b0, "reset");
    rst = 1'b0;

    opcode = 4'b0001;
    fetch(1, "add_pre");
    cyc(1, S4, C_IR_OUT | C_MAR, 1'b0, "add_pre_t4");
    #1 rst = 1'b1;
    cyc(1, S1, C_PC_OUT | C_MAR, 1'b0, "rst_mid_t5");
    rst = 1'b0;

    opcode = 4'b0101;
    fetch(1, "ldi");
    cyc(1, S4, C_IR_OUT | C_A_LOAD, 1'b0, "ldi_t4");
    opcode = 4'b0001;
    fetch(1, "add");
    cyc(1, S4, C_IR_OUT | C_MAR, 1'b0, "add_t4");
    cyc(1, S5, C_RAM_OUT | C_B_LOAD, 1'b0, "add_t5");
    cyc(1, S6, C_ALU_OUT | C_A_LOAD, 1'b0, "add_t6");

    opcode = 4'b0010;
    fetch(1, "sub");
    cyc(1, S4, C_IR_OUT | C_MAR, 1'b0, "sub_t4");
    cyc(1, S5, C_RAM_OUT | C_B_LOAD | C_SUB, 1'b0, "sub_t5");
    cyc(1, S6, C_ALU_OUT | C_A_LOAD | C_SUB, 1'b0, "sub_t6");
    opcode = 4'b0100;
    fetch(1, "sta");
    cyc(1, S4, C_IR_OUT | C_MAR, 1'b0, "sta_t4");
    cyc(1, S5, C_A_OUT | C_RAM_IN, 1'b0, "sta_t5");
    opcode = 4'b0000;
    fetch(1, "lda");
    cyc(1, S4, C_IR_OUT | C_MAR, 1'b0, "lda_t4");
    cyc(1, S5, C_RAM_OUT | C_A_LOAD, 1'b0, "lda_t5");

    opcode = 4'b1000; flag_z = 1'b1; flag_c = 1'b0;
    fetch(1, "jz_taken");
    cyc(1, S4, C_IR_OUT | C_PC_LOAD, 1'b0, "jz_taken_t4");
    flag_z = 1'b0; flag_c = 1'b1;
    fetch(1, "jz_not");
    cyc(1, S4, C_NONE, 1'b0, "jz_not_t4");
    opcode = 4'b0111;
    fetch(1, "jc_taken");
    cyc(1, S4, C_IR_OUT | C_PC_LOAD, 1'b0, "jc_taken_t4");
    flag_c = 1'b0; flag_z = 1'b1;
    fetch(1, "jc_not");
    cyc(1, S4, C_NONE, 1'b0, "jc_not_t4");
    flag_z = 1'b0;
    opcode = 4'b0110;
    fetch(1, "jmp");
    cyc(1, S4, C_IR_OUT | C_PC_LOAD, 1'b0, "jmp_t4");
    opcode = 4'b1110;
    fetch(1, "out");
    cyc(1, S4, C_A_OUT | C_OUT_LOAD, 1'b0, "out_t4");
    opcode = 4'b0011;
    fetch(1, "undef");
    cyc(1, S4, C_NONE, 1'b0, "undef_t4");

    opcode = 4'b0101;
    cyc(1, S1, C_PC_OUT | C_MAR, 1'b0, "step_t1");
    step_en = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, S2, C_PC_INC, 1'b0, "step_hold_t2");
    step_en = 1'b1;
    cyc(1, S2, C_PC_INC, 1'b0, "step_go_t2");
    cyc(1, S3, C_RAM_OUT | C_IR_LOAD, 1'b0, "step_t3");
    cyc(1, S4, C_IR_OUT | C_A_LOAD, 1'b0, "step_t4");

    opcode = 4'b1111;
    fetch(1, "hlt");
    step_en = 1'b0;
    cyc(1, S4, C_NONE, 1'b0, "hlt_t4_stalled");
    step_en = 1'b1;
    cyc(1, S4, C_NONE, 1'b0, "hlt_t4");
    for (int i = 0; i < 20; i++) begin
      step_en = i[0];
      if (i >= 10) opcode = 4'b0000;
      cyc(1, S5, C_NONE, 1'b1, "halted_frozen");
    end
    step_en = 1'b1;
    #1 rst = 1'b1;
    cyc(1, S1, C_PC_OUT | C_MAR, 1'b0, "halt_rst");
    rst = 1'b0;

    opcode = 4'b0101;
    fetch(0, "c_ldi");
    cyc(0, S4, C_IR_OUT | C_A_LOAD, 1'b0, "c_ldi_t4");
    cyc(0, S5, C_NONE, 1'b0, "c_ldi_t5");
    cyc(0, S6, C_NONE, 1'b0, "c_ldi_t6");
    opcode = 4'b0001;
    fetch(0, "c_add");
    cyc(0, S4, C_IR_OUT | C_MAR, 1'b0, "c_add_t4");
    cyc(0, S5, C_RAM_OUT | C_B_LOAD, 1'b0, "c_add_t5");
    cyc(0, S6, C_ALU_OUT | C_A_LOAD, 1'b0, "c_add_t6");
    cyc(0, S1, C_PC_OUT | C_MAR, 1'b0, "c_wrap_t1");

    @(negedge clk);
    #1;
    n_checks = n_checks + 1;
    if (q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sap_ctrl_seq.md
Name: sap_ctrl_seq

Overview:
Parametrised SAP-class controller-sequencer. It drives the control word for the PC, MAR, RAM, IR, A, B, ALU and OUT blocks of the 8-bit SAP core.
Successor to the fixed 6-T-state SAP-1 controller, with these additions:
- extended instruction set: STA, LDI, JMP, JC, JZ
- variable-length execute phase (early ring reset)
- single-step enable
- sticky halt
It sits between the IR opcode field and the datapath enables inside the core top.

Parameters:
OPW, 4, opcode width taken from the IR high bits (4..8; upper bits beyond 4 must be 0 for a defined opcode).
EARLY_END, 1, 1 = return to T1 after the last active execute step; 0 = always run all six T-states (classic SAP-1 timing).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
step_en  in  1  T-state advances only on edges where step_en=1 (tie 1 for free-run)
opcode  in  OPW  IR opcode field
flag_c  in  1  ALU carry flag (registered in datapath)
flag_z  in  1  ALU zero flag (registered in datapath)
t_state  out  6  one-hot current T-state, bit0 = T1
pc_inc  out  1  PC increment
pc_out  out  1  PC drives bus
pc_load  out  1  PC loads from bus
mar_load  out  1  MAR loads from bus
ram_out  out  1  RAM drives bus
ram_in  out  1  RAM writes from bus
ir_load  out  1  IR loads from bus
ir_out  out  1  IR operand drives bus
a_load  out  1  A loads
a_out  out  1  A drives bus
b_load  out  1  B loads
alu_sub  out  1  ALU subtract select
alu_out  out  1  ALU drives bus
out_load  out  1  output register loads
halted  out  1  sticky halt indicator

Behaviour:
- State: T-state ring (one-hot, 6 bits) plus halted flag. Control outputs are combinational decode of (t_state, opcode, flags, halted).
- Reset (async, any time, including mid-instruction or while halted):
  - t_state=6'b000001 and halted=0.
  - Outputs while in reset equal the T1 decode: pc_out=1, mar_load=1, all other controls 0.
- Advance:
  - On a rising edge with step_en=1 and halted=0, the ring rotates T(n)->T(n+1), T6->T1.
  - With EARLY_END=1 and the current step marked "last", the ring goes to T1 instead.
  - With step_en=0 the state holds. Outputs stay asserted for the held state, so a held load re-loads each cycle; this is harmless.
- Fetch, all opcodes:
  - T1: pc_out, mar_load
  - T2: pc_inc
  - T3: ram_out, ir_load
- Execute, T4..T6 (L = last step):
  - LDA 0000: T4 ir_out, mar_load; T5 ram_out, a_load (L)
  - ADD 0001: T4 ir_out, mar_load; T5 ram_out, b_load; T6 alu_out, a_load (L)
  - SUB 0010: as ADD, with alu_sub=1 in T5 and T6
  - STA 0100: T4 ir_out, mar_load; T5 a_out, ram_in (L)
  - LDI 0101: T4 ir_out, a_load (L)
  - JMP 0110: T4 ir_out, pc_load (L)
  - JC 0111: T4 ir_out, pc_load only if flag_c=1; otherwise nothing (L either way)
  - JZ 1000: same as JC using flag_z
  - OUT 1110: T4 a_out, out_load (L)
  - HLT 1111: T4 all controls 0. halted sets on the edge leaving T4, only if step_en=1.
  - Undefined opcodes: no controls, T4 is L.
- Flags are sampled combinationally during T4 only.
- EARLY_END=0: steps after L assert no controls. The ring still traverses to T6, then T1.
- Halted:
  - Ring frozen at T5; all control outputs 0; step_en ignored.
  - Exit only via rst.
- Instruction cycle counts with EARLY_END=1: LDI/JMP/Jcc/OUT/NOP 4, LDA/STA 5, ADD/SUB 6. All instructions take 6 with EARLY_END=0.
- At most one bus driver is asserted in any state. The bench asserts this.

Decomposition:
- Shared package sap_pkg holds:
  - opcode constants (OP_LDA .. OP_HLT, zero-extended to OPW)
  - T-state index constants T1..T6
  - control-word bit positions, plus a packed control-word typedef shared with the datapath
- Sub-module sap_tstate_ring:
  - 6-bit one-hot ring with async rst, enable and synchronous clear-to-T1 input
  - hold input driven by halted
- The decode stays in sap_ctrl_seq.

Test Plan:
1. Reset mid-T5 of ADD -> t_state=000001 immediately, before the next edge; pc_out=1, mar_load=1, halted=0.
2. EARLY_END=1, program LDI(0101) -> exactly 4 cycles. T4 shows ir_out=1, a_load=1; next cycle t_state=000001. Then ADD(0001): T6 alu_out=1, a_load=1; 6 cycles total.
3. SUB(0010) -> alu_sub=1 in T5 and T6 only. STA(0100) -> T5 a_out=1, ram_in=1, then T1.
4. JZ(1000): flag_z=1 -> T4 pc_load=1, ir_out=1. flag_z=0 -> all controls 0 in T4. Both return to T1 after 4 cycles. Repeat for JC with flag_c.
5. step_en=0 for 3 cycles during T2 -> t_state stays 000010 with pc_inc=1; advances to T3 on the first edge with step_en=1.
6. HLT(1111) -> after T4 halted=1, t_state=010000, all controls 0 for 20 cycles regardless of step_en; rst pulse -> T1, halted=0. With EARLY_END=0, repeat the LDI check -> 6 cycles, T5/T6 controls all 0.
